mult8_mac_stream: RTL and testbench

Streaming multiply-accumulate stage built around the team's combinational 8x8 unsigned multiplier (ports A[7:0], B[7:0], P[15:0]).
- Accepts a packet of operand pairs on a valid/ready input.
- Registers the operands, multiplies them, registers the product, and accumulates the products.
- Emits one accumulated result per packet on a valid/ready output.
- Sits directly downstream of the operand source and consumes every product the multiplier produces; the multiplier core is instantiated unmodified.

---
 rtl/mac_pkg.sv | 16 +
 rtl/mult8.sv | 14 +
 rtl/mult8_mac_datapath.sv | 88 ++++++++
 rtl/mult8_mac_stream.sv | 107 ++++++++++
 tb/tb_mult8_mac_stream.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the mult8 multiply-accumulate stream stage.
// Holds the control FSM state type, the default widths and the product width
// of the 8x8 multiplier core.
package mac_pkg;

    typedef enum logic [1:0] {
        StAcc,   // accepting operand beats
        StDrain, // last beat accepted, waiting for it to reach the accumulator
        StHold   // result presented, waiting for the output handshake
    } state_e;

    localparam int unsigned DEFAULT_ACC_W = 24;
    localparam int unsigned DEFAULT_CNT_W = 8;
    localparam int unsigned PROD_W        = 16;

endpackage

// File: rtl/mult8.sv
// Combinational 8x8 unsigned multiplier core.
// Ports:
//   A [7:0]  multiplicand
//   B [7:0]  multiplier
//   P [15:0] exact product (255*255 = 65025 fits)
module mult8 (
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] P
);

    assign P = 16'(A) * 16'(B);

endmodule

// File: rtl/mult8_mac_datapath.sv
// Datapath of the MAC stream stage: operand register (S1), multiplier,
// product register (S2), accumulator and sticky overflow flag.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   beat_i        an operand beat is accepted this cycle
//   a_i, b_i      operands of the accepted beat
//   last_i        accepted beat closes the packet
//   clr_i         clear accumulator and overflow (output handshake)
//   acc_o         running sum modulo 2^ACC_W
//   ovf_o         sticky carry-out of the accumulator
//   last_done_o   the closing beat is being accumulated this cycle
module mult8_mac_datapath
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = DEFAULT_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beat_i,
    input  logic [7:0]       a_i,
    input  logic [7:0]       b_i,
    input  logic             last_i,
    input  logic             clr_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             ovf_o,
    output logic             last_done_o
);

    logic [7:0]        a1_q, b1_q;
    logic              last1_q, v1_q;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] p2_q;
    logic              last2_q, v2_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [ACC_W:0]    sum;

    mult8 u_mult (
        .A(a1_q),
        .B(b1_q),
        .P(prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a1_q    <= '0;
            b1_q    <= '0;
            last1_q <= 1'b0;
            v1_q    <= 1'b0;
            p2_q    <= '0;
            last2_q <= 1'b0;
            v2_q    <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            v1_q <= beat_i;
            if (beat_i) begin
                a1_q    <= a_i;
                b1_q    <= b_i;
                last1_q <= last_i;
            end
            v2_q    <= v1_q;
            last2_q <= last1_q;
            p2_q    <= prod;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // One extra bit on the sum exposes the carry out of the accumulator.
    always_comb begin
        sum   = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, p2_q};
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (v2_q) begin
            acc_d = sum[ACC_W-1:0];
            ovf_d = ovf_q | sum[ACC_W];
        end
    end

    assign acc_o       = acc_q;
    assign ovf_o       = ovf_q;
    assign last_done_o = v2_q & last2_q;

endmodule

// File: rtl/mult8_mac_stream.sv
// Streaming multiply-accumulate stage. Accepts a packet of 8-bit operand
// pairs, sums their products and emits one result per packet.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   in_valid/in_ready         operand beat handshake
//   in_a, in_b, in_last       operands and end-of-packet marker
//   out_valid/out_ready       result handshake
//   out_acc                   sum of packet products modulo 2^ACC_W
//   out_count                 beats in packet, saturating at all-ones
//   out_ovf                   sticky: some accumulate carried out of ACC_W
module mult8_mac_stream
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = DEFAULT_ACC_W,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             clr;
    logic             last_done;
    logic [ACC_W-1:0] acc;
    logic             ovf;

    // Outputs are forced low while rst is held, before the reset edge lands.
    assign in_ready  = ~rst & (state_q == StAcc);
    assign out_valid = ~rst & (state_q == StHold);
    assign accept    = in_valid & in_ready;

    mult8_mac_datapath #(
        .ACC_W(ACC_W)
    ) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .beat_i     (accept),
        .a_i        (in_a),
        .b_i        (in_b),
        .last_i     (in_last),
        .clr_i      (clr),
        .acc_o      (acc),
        .ovf_o      (ovf),
        .last_done_o(last_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAcc;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        unique case (state_q)
            StAcc: begin
                if (accept && in_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (last_done) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StAcc;
                    clr     = 1'b1;
                end
            end
            default: state_d = StAcc;
        endcase
    end

    // Beat counter saturates at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (accept && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign out_acc   = rst ? '0 : acc;
    assign out_count = rst ? '0 : cnt_q;
    assign out_ovf   = ~rst & ovf;

endmodule

// File: tb/tb_mult8_mac_stream.sv
// Directed bench for mult8_mac_stream. Three instances share one stimulus
// stream: default widths, ACC_W=16 and CNT_W=2.
module tb_mult8_mac_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_last;
    logic        out_ready;

    logic        rdy24, val24, ovf24;
    logic [23:0] acc24;
    logic [7:0]  cnt24;
    logic        rdy16, val16, ovf16;
    logic [15:0] acc16;
    logic [7:0]  cnt16;
    logic        rdyc2, valc2, ovfc2;
    logic [23:0] accc2;
    logic [1:0]  cntc2;

    int n_checks = 0;
    int n_miscompares = 0;

    always #5 clk = ~clk;

    mult8_mac_stream #(.ACC_W(24), .CNT_W(8)) u_dut24 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy24), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .out_valid(val24), .out_ready(out_ready), .out_acc(acc24),
        .out_count(cnt24), .out_ovf(ovf24)
    );

    mult8_mac_stream #(.ACC_W(16), .CNT_W(8)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .out_valid(val16), .out_ready(out_ready), .out_acc(acc16),
        .out_count(cnt16), .out_ovf(ovf16)
    );

    mult8_mac_stream #(.ACC_W(24), .CNT_W(2)) u_dutc2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyc2), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .out_valid(valc2), .out_ready(out_ready), .out_acc(accc2),
        .out_count(cntc2), .out_ovf(ovfc2)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        last;
        logic [23:0] acc24;
        logic [15:0] acc16;
        logic        ovf16;
        logic [7:0]  cnt8;
        logic [1:0]  cnt2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic last,
                                input logic [23:0] e24, input logic [15:0] e16,
                                input logic eovf16, input logic [7:0] ec8,
                                input logic [1:0] ec2);
        vec_t v;
        v.a = a; v.b = b; v.last = last;
        v.acc24 = e24; v.acc16 = e16; v.ovf16 = eovf16; v.cnt8 = ec8; v.cnt2 = ec2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d at %0t", name, act, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a beat, wait (bounded) for in_ready, return just after the accept edge.
    task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        while (!rdy24 && n < 50) begin
            tick();
            n++;
        end
        if (!rdy24) chk("in_ready_timeout", 32'(rdy24), 32'd1);
        tick();
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        in_last  = 1'($urandom);
    endtask

    // Called just after the last beat's accept edge t: checks t+2 latency,
    // result fields of all instances, then completes the output handshake.
    task automatic finish_packet(input vec_t v);
        chk("in_ready_after_last", 32'(rdy24), 32'd0);
        chk("out_valid_t0", 32'(val24), 32'd0);
        tick();
        chk("out_valid_t1", 32'(val24), 32'd0);
        tick();
        chk("out_valid_t2", 32'(val24), 32'd1);
        chk("acc24", 32'(acc24), 32'(v.acc24));
        chk("cnt24", 32'(cnt24), 32'(v.cnt8));
        chk("ovf24", 32'(ovf24), 32'd0);
        chk("acc16", 32'(acc16), 32'(v.acc16));
        chk("ovf16", 32'(ovf16), 32'(v.ovf16));
        chk("cnt_c2", 32'(cntc2), 32'(v.cnt2));
        chk("acc_c2", 32'(accc2), 32'(v.acc24));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_after_hs", 32'(val24), 32'd0);
        chk("in_ready_after_hs", 32'(rdy24), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;

        // Packet table: expected fields are meaningful on last beats only.
        vecs.push_back(mk(8'd255, 8'd255, 1'b1, 24'd65025, 16'd65025, 1'b0, 8'd1, 2'd1));
        vecs.push_back(mk(8'd3, 8'd4, 1'b0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8'd5, 8'd6, 1'b0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8'd7, 8'd8, 1'b1, 24'd98, 16'd98, 1'b0, 8'd3, 2'd3));
        vecs.push_back(mk(8'd255, 8'd255, 1'b0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8'd255, 8'd255, 1'b1, 24'd130050, 16'd64514, 1'b1, 8'd2, 2'd2));
        vecs.push_back(mk(8'd2, 8'd2, 1'b1, 24'd4, 16'd4, 1'b0, 8'd1, 2'd1));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(8'd1, 8'd1, 1'b0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8'd1, 8'd1, 1'b1, 24'd5, 16'd5, 1'b0, 8'd5, 2'd3));
        vecs.push_back(mk(8'd0, 8'd200, 1'b0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8'd200, 8'd0, 1'b0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8'd17, 8'd19, 1'b1, 24'd323, 16'd323, 1'b0, 8'd3, 2'd3));
        vecs.push_back(mk(8'd128, 8'd2, 1'b0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8'd100, 8'd100, 1'b1, 24'd10256, 16'd10256, 1'b0, 8'd2, 2'd2));

        // Reset state.
        #1;
        chk("rst_in_ready", 32'(rdy24), 32'd0);
        chk("rst_out_valid", 32'(val24), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(rdy24), 32'd1);
        chk("post_rst_out_valid", 32'(val24), 32'd0);
        chk("post_rst_acc", 32'(acc24), 32'd0);
        chk("post_rst_count", 32'(cnt24), 32'd0);
        chk("post_rst_ovf", 32'(ovf24), 32'd0);

        foreach (vecs[i]) begin
            send_beat(vecs[i].a, vecs[i].b, vecs[i].last);
            if (vecs[i].last) finish_packet(vecs[i]);
        end

        // Backpressure: result held for 10 cycles while a new beat is stalled.
        send_beat(8'd3, 8'd4, 1'b0);
        send_beat(8'd5, 8'd6, 1'b0);
        send_beat(8'd7, 8'd8, 1'b1);
        tick();
        tick();
        in_valid = 1'b1; in_a = 8'd2; in_b = 8'd3; in_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 32'(val24), 32'd1);
            chk("bp_out_acc", 32'(acc24), 32'd98);
            chk("bp_in_ready", 32'(rdy24), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_in_ready_after_hs", 32'(rdy24), 32'd1);
        tick();
        in_valid = 1'b0;
        finish_packet(mk(8'd2, 8'd3, 1'b1, 24'd6, 16'd6, 1'b0, 8'd1, 2'd1));

        // Reset in the middle of an unfinished packet.
        send_beat(8'd9, 8'd9, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(rdy24), 32'd0);
        chk("midrst_out_valid", 32'(val24), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #0;
            chk("midrst_no_valid", 32'(val24), 32'd0);
            chk("midrst_acc_clear", 32'(acc24), 32'd0);
            in_a = 8'd77; in_b = 8'd66; in_last = 1'b1;
            tick();
        end
        send_beat(8'd1, 8'd1, 1'b1);
        finish_packet(mk(8'd1, 8'd1, 1'b1, 24'd1, 16'd1, 1'b0, 8'd1, 2'd1));

        // out_ready held high throughout a packet has no early effect.
        out_ready = 1'b1;
        send_beat(8'd6, 8'd7, 1'b0);
        send_beat(8'd1, 8'd1, 1'b1);
        chk("ordy_valid_t0", 32'(val24), 32'd0);
        tick();
        chk("ordy_valid_t1", 32'(val24), 32'd0);
        tick();
        chk("ordy_valid_t2", 32'(val24), 32'd1);
        chk("ordy_acc", 32'(acc24), 32'd43);
        chk("ordy_count", 32'(cnt24), 32'd2);
        tick();
        out_ready = 1'b0;
        chk("ordy_valid_after_hs", 32'(val24), 32'd0);
        chk("ordy_in_ready_after_hs", 32'(rdy24), 32'd1);
        chk("ordy_acc_cleared", 32'(acc24), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompares);
        $finish;
    end

endmodule
